// File: rtl/sdram_init_checker_if.sv
// SDRAM command-bus monitor interface.
// Carries the observed SDRAM command/address (driven by the initializer, the master side)
// and the checker's status outputs (driven by the checker, the slave side).
//   command   : {cs_n, ras_n, cas_n, we_n}
//   address   : SDRAM address bus, ASIZE bits
//   ready     : legal init sequence completed
//   error     : sticky violation flag
//   err_code  : first-violation cause
//   mode_reg  : address captured at MSET
//   cas_lat   : mode_reg[6:4]
//   burst_len : mode_reg[2:0]
interface sdram_init_checker_if #(
    parameter int unsigned ASIZE = 12
);
    logic [3:0]       command;
    logic [ASIZE-1:0] address;
    logic             ready;
    logic             error;
    logic [2:0]       err_code;
    logic [ASIZE-1:0] mode_reg;
    logic [2:0]       cas_lat;
    logic [2:0]       burst_len;

    modport master (
        output command, address,
        input  ready, error, err_code, mode_reg, cas_lat, burst_len
    );

    modport slave (
        input  command, address,
        output ready, error, err_code, mode_reg, cas_lat, burst_len
    );
endinterface

// File: rtl/sdram_init_checker.sv
// Passive checker for the SDRAM power-up sequence.
// Watches PRE-all, two AREFs and MSET on the command bus, checks their order and
// spacing, validates the mode word, and reports ready or a sticky error with cause.
// Ports:
//   clk_100m : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : slave side of sdram_init_checker_if (command/address in, status out)
module sdram_init_checker #(
    parameter int unsigned ASIZE    = 12,
    parameter int unsigned INIT_PRE = 20000,
    parameter int unsigned T_RP     = 2,
    parameter int unsigned T_RFC    = 7,
    parameter int unsigned T_MRD    = 3
) (
    input  logic                 clk_100m,
    input  logic                 rst,
    sdram_init_checker_if.slave  bus
);
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MSET = 4'b0000;

    localparam logic [15:0] InitPreG = 16'(INIT_PRE);
    localparam logic [15:0] TRpG     = 16'(T_RP);
    localparam logic [15:0] TRfcG    = 16'(T_RFC);
    localparam logic [15:0] TMrdG    = 16'(T_MRD);

    localparam logic [2:0] ErrNone  = 3'd0;
    localparam logic [2:0] ErrEarly = 3'd1;
    localparam logic [2:0] ErrOrder = 3'd2;
    localparam logic [2:0] ErrSpace = 3'd3;
    localparam logic [2:0] ErrMode  = 3'd4;

    typedef enum logic [2:0] {
        StPwrup, StWPre, StWRef1, StWRef2, StWMrs, StMrd, StReady, StErr
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      gap_q, gap_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [ASIZE-1:0] mode_reg_q, mode_reg_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;

    logic is_nop, is_pre, is_aref, is_mset, a10;

    // cs_n high deselects the device, so it counts as NOP whatever the other bits are.
    assign is_nop  = bus.command[3] || (bus.command == C_NOP);
    assign is_pre  = (bus.command == C_PRE);
    assign is_aref = (bus.command == C_AREF);
    assign is_mset = (bus.command == C_MSET);
    assign a10     = bus.address[10];

    function automatic logic mode_ok(input logic [ASIZE-1:0] a);
        logic bl_ok, cl_ok;
        bl_ok = !(a[2:0] inside {3'b100, 3'b101, 3'b110});
        cl_ok = (a[6:4] == 3'b010) || (a[6:4] == 3'b011);
        return bl_ok && cl_ok;
    endfunction

    // Gap is the pre-increment count since the last non-NOP command; saturates so long
    // idle periods never wrap back into the "too early" range.
    always_comb begin
        gap_d = gap_q;
        if (!is_nop) begin
            gap_d = 16'd1;
        end else if (gap_q != 16'hFFFF) begin
            gap_d = gap_q + 16'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        mode_reg_d = mode_reg_q;

        unique case (state_q)
            StPwrup, StWPre: begin
                if (!is_nop) begin
                    if (state_q == StPwrup && gap_q < InitPreG) begin
                        state_d    = StErr;
                        err_code_d = ErrEarly;
                    end else if (is_pre && a10) begin
                        state_d = StWRef1;
                    end else begin
                        state_d    = StErr;
                        err_code_d = ErrOrder;
                    end
                end
            end
            StWRef1, StWRef2: begin
                if (!is_nop) begin
                    if (!is_aref) begin
                        state_d    = StErr;
                        err_code_d = ErrOrder;
                    end else if (gap_q < ((state_q == StWRef1) ? TRpG : TRfcG)) begin
                        state_d    = StErr;
                        err_code_d = ErrSpace;
                    end else begin
                        state_d = (state_q == StWRef1) ? StWRef2 : StWMrs;
                    end
                end
            end
            StWMrs: begin
                if (!is_nop) begin
                    if (!(is_aref || is_mset)) begin
                        state_d    = StErr;
                        err_code_d = ErrOrder;
                    end else if (gap_q < TRfcG) begin
                        state_d    = StErr;
                        err_code_d = ErrSpace;
                    end else if (is_mset) begin
                        // Captured even when the word is rejected, to aid debug.
                        mode_reg_d = bus.address;
                        if (mode_ok(bus.address)) begin
                            state_d = StMrd;
                        end else begin
                            state_d    = StErr;
                            err_code_d = ErrMode;
                        end
                    end
                end
            end
            StMrd: begin
                if (!is_nop && gap_q < TMrdG) begin
                    state_d    = StErr;
                    err_code_d = ErrSpace;
                end else if (gap_q >= TMrdG) begin
                    state_d = StReady;
                end
            end
            StReady, StErr: ;
            default: state_d = StPwrup;
        endcase

        ready_d = (state_d == StReady);
        error_d = (state_d == StErr);
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_q    <= StPwrup;
            gap_q      <= '0;
            err_code_q <= ErrNone;
            mode_reg_q <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            err_code_q <= err_code_d;
            mode_reg_q <= mode_reg_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.error     = error_q;
    assign bus.err_code  = err_code_q;
    assign bus.mode_reg  = mode_reg_q;
    assign bus.cas_lat   = mode_reg_q[6:4];
    assign bus.burst_len = mode_reg_q[2:0];
endmodule

// File: tb/tb_sdram_init_checker.sv
// Scoreboard bench for sdram_init_checker with shortened power-up delay.
module tb_sdram_init_checker;
    localparam int unsigned ASIZE = 12;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MSET = 4'b0000;

    typedef struct packed {
        logic             ready;
        logic             error;
        logic [2:0]       code;
        logic [ASIZE-1:0] mode;
        logic [2:0]       cl;
        logic [2:0]       bl;
    } obs_t;

    logic clk_100m = 1'b0;
    logic rst      = 1'b1;

    sdram_init_checker_if #(.ASIZE(ASIZE)) bus ();

    sdram_init_checker #(
        .ASIZE(ASIZE), .INIT_PRE(200), .T_RP(2), .T_RFC(7), .T_MRD(3)
    ) dut (
        .clk_100m (clk_100m),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_100m = ~clk_100m;

    obs_t exp_q[$];
    obs_t got, want;
    int   passed = 0;
    int   total  = 0;

    // Expected-value model: cas_lat/burst_len are fields of the captured mode word.
    function automatic obs_t mk(input logic r, input logic e, input logic [2:0] c,
                                input logic [ASIZE-1:0] m);
        obs_t o;
        o.ready = r; o.error = e; o.code = c; o.mode = m;
        o.cl = m[6:4]; o.bl = m[2:0];
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ready = bus.ready; o.error = bus.error; o.code = bus.err_code;
        o.mode = bus.mode_reg; o.cl = bus.cas_lat; o.bl = bus.burst_len;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [3:0] cmd, input logic [ASIZE-1:0] addr);
        bus.command = cmd;
        bus.address = addr;
        tick();
        bus.command = C_NOP;
        bus.address = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.command = C_NOP;
        bus.address = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // PRE-all at pre_gap, then AREF at gap 2 and AREF at gap 7: leaves DUT in W_MRS.
    task automatic legal_prefix(input int pre_gap);
        idle(pre_gap);
        send(C_PRE, 12'h400);
        idle(1);
        send(C_AREF, '0);
        idle(6);
        send(C_AREF, '0);
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back(mk(0, 0, 0, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL reset_state: got %h want %h", got, want);
        else passed++;
        idle(10);
        exp_q.push_back(mk(0, 0, 0, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL pwrup_idle: got %h want %h", got, want);
        else passed++;
    endtask

    task automatic test_legal();
        do_reset();
        legal_prefix(201);
        idle(6);
        send(C_MSET, 12'h032);
        exp_q.push_back(mk(0, 0, 0, 12'h032));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL legal_mset_edge: got %h want %h", got, want);
        else passed++;
        idle(2);
        exp_q.push_back(mk(0, 0, 0, 12'h032));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL legal_mrd_wait: got %h want %h", got, want);
        else passed++;
        idle(1);
        exp_q.push_back(mk(1, 0, 0, 12'h032));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL legal_ready: got %h want %h", got, want);
        else passed++;
        send(C_PRE, 12'h000);
        send(C_MSET, 12'h0FF);
        exp_q.push_back(mk(1, 0, 0, 12'h032));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL ready_terminal: got %h want %h", got, want);
        else passed++;
    endtask

    task automatic test_early();
        do_reset();
        idle(150);
        send(C_PRE, 12'h400);
        exp_q.push_back(mk(0, 1, 3'd1, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL early_150: got %h want %h", got, want);
        else passed++;
        do_reset();
        idle(199);
        send(C_PRE, 12'h400);
        exp_q.push_back(mk(0, 1, 3'd1, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL early_199: got %h want %h", got, want);
        else passed++;
    endtask

    task automatic test_partial_pre();
        do_reset();
        idle(201);
        send(C_PRE, 12'h000);
        exp_q.push_back(mk(0, 1, 3'd2, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL partial_pre: got %h want %h", got, want);
        else passed++;
        send(C_AREF, '0);
        exp_q.push_back(mk(0, 1, 3'd2, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL sticky_code: got %h want %h", got, want);
        else passed++;
    endtask

    task automatic test_refresh_spacing();
        do_reset();
        idle(201);
        send(C_PRE, 12'h400);
        send(C_AREF, '0);  // gap 1 < T_RP
        exp_q.push_back(mk(0, 1, 3'd3, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL trp_short: got %h want %h", got, want);
        else passed++;
        do_reset();
        idle(201);
        send(C_PRE, 12'h400);
        idle(1);
        send(C_AREF, '0);
        idle(4);
        send(C_AREF, '0);  // gap 5 < T_RFC
        exp_q.push_back(mk(0, 1, 3'd3, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL trfc_short: got %h want %h", got, want);
        else passed++;
        do_reset();
        legal_prefix(201);
        idle(6);
        send(C_AREF, '0);  // third refresh at exactly T_RFC
        exp_q.push_back(mk(0, 0, 3'd0, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL extra_aref: got %h want %h", got, want);
        else passed++;
        idle(6);
        send(C_MSET, 12'h032);
        idle(3);
        exp_q.push_back(mk(1, 0, 3'd0, 12'h032));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL extra_aref_ready: got %h want %h", got, want);
        else passed++;
    endtask

    task automatic test_bad_mode();
        do_reset();
        legal_prefix(201);
        idle(6);
        send(C_MSET, 12'h012);
        exp_q.push_back(mk(0, 1, 3'd4, 12'h012));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL bad_cl: got %h want %h", got, want);
        else passed++;
        do_reset();
        legal_prefix(201);
        idle(6);
        send(C_MSET, 12'h034);
        exp_q.push_back(mk(0, 1, 3'd4, 12'h034));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL bad_bl: got %h want %h", got, want);
        else passed++;
    endtask

    task automatic test_mrd();
        do_reset();
        legal_prefix(201);
        idle(6);
        send(C_MSET, 12'h037);
        idle(1);
        send(C_AREF, '0);  // gap 2 < T_MRD
        exp_q.push_back(mk(0, 1, 3'd3, 12'h037));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL tmrd_short: got %h want %h", got, want);
        else passed++;
        do_reset();
        legal_prefix(201);
        idle(6);
        send(C_MSET, 12'h023);
        idle(2);
        send(C_AREF, '0);  // gap exactly T_MRD
        exp_q.push_back(mk(1, 0, 3'd0, 12'h023));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL tmrd_exact: got %h want %h", got, want);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        legal_prefix(201);
        send(C_PRE, 12'h400);  // make error set too, then check reset clears it
        rst = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 3'd0, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL async_reset: got %h want %h", got, want);
        else passed++;
        do_reset();
        legal_prefix(200);  // first command at exactly INIT_PRE
        idle(6);
        send(C_MSET, 12'h033);
        idle(3);
        exp_q.push_back(mk(1, 0, 3'd0, 12'h033));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL after_reset_ready: got %h want %h", got, want);
        else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        idle(65540);  // would wrap to 4 without saturation
        send(C_PRE, 12'h400);
        exp_q.push_back(mk(0, 0, 3'd0, '0));
        got = sample(); want = exp_q.pop_front(); total++;
        if (got !== want) $display("FAIL gap_saturate: got %h want %h", got, want);
        else passed++;
    endtask

    initial begin
        bus.command = C_NOP;
        bus.address = '0;
        test_reset();
        test_legal();
        test_early();
        test_partial_pre();
        test_refresh_spacing();
        test_bad_mode();
        test_mrd();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
